uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver feeding the UART/ALU top. It adds:
- configurable data width, parity and stop bits
- runtime baud divisor with an internal oversampling tick generator
- 3-sample majority voting
- a valid/ready output register with framing, parity and overrun reporting

Sits between the UART_TXD_IN pin synchroniser and the command interface FSM.

Parameters:
NB_DATA, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit; power of two, >= 8
NB_DIV, 16, width of runtime divisor
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
NB_STOP, 1, stop bits checked (1 or 2)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active-low
i_en  in  1  receiver enable
i_div  in  NB_DIV  clocks per oversample tick; 0 treated as 1
i_rx  in  1  serial input, asynchronous to i_clk
i_ready  in  1  consumer accepts o_data
o_data  out  NB_DATA  received word
o_valid  out  1  o_data/o_frame_err/o_parity_err valid
o_frame_err  out  1  stop bit sampled 0 in the delivered frame
o_parity_err  out  1  parity mismatch in the delivered frame; 0 when PARITY_MODE = 0
o_overrun  out  1  sticky: a completed frame was dropped
o_busy  out  1  FSM not in IDLE

Behaviour:
Reset values (i_rst_n low, asynchronous):
- state IDLE; synchroniser flops 1
- o_data 0; o_valid, o_frame_err, o_parity_err, o_overrun, o_busy all 0
- tick and sample counters 0

Input path:
- i_rx passes a 2-flop synchroniser before any use (2-cycle input latency).

Tick generator:
- Counts i_div clocks per tick.
- Counter restarts when IDLE detects a start edge.
- i_div is latched at start detection; changes mid-frame take effect next frame.

FSM states and transitions:
- IDLE: o_busy = 0. A falling edge on the synchronised rx with i_en = 1 -> START, tick/sample counters cleared.
- START: majority vote of samples at ticks OVERSAMPLE/2-1, /2, /2+1. Vote = 1 -> false start, back to IDLE, nothing reported. Otherwise wait to the end of the bit -> DATA.
- DATA: NB_DATA bits, each majority-voted at mid-bit, shifted in LSB first. After the last bit -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: voted bit compared with XOR of the data (even), or its inverse (odd).
- STOP: voted at mid-bit; 0 -> frame error.
  - With NB_STOP = 2, the first stop bit waits a full bit, then the second is checked; an error on either sets the flag.
  - The frame completes at the mid-stop vote of the last stop bit. The FSM returns to IDLE at once, so a start edge arriving half a bit later is caught.
- i_en low in any state: FSM goes to IDLE on the next clock; the partial frame is discarded; the output register is untouched.

Output register:
- On completion with o_valid = 0, or with o_valid && i_ready in the same cycle:
  - o_data, o_frame_err and o_parity_err load on the next edge; o_valid = 1.
- On completion with o_valid && !i_ready:
  - the new frame is dropped; old data is held; o_overrun set.
- Handshake o_valid && i_ready with no completion that cycle: o_valid clears next edge.
- o_overrun is sticky; it clears on the next accepted handshake.
- Frames with errors are still delivered, with their flags.

Latency:
- o_valid rises 1 clock after the final mid-stop vote tick.

Decomposition:
Package uart_pkg holds:
- FSM state encoding (IDLE, START, DATA, PARITY, STOP)
- PARITY_NONE/EVEN/ODD constants
- the majority-vote function

One sub-module, uart_tick_gen (divisor counter, restart input, tick output), is shared with the future parametrised transmitter.

Test Plan:
All scenarios use i_div = 325, OVERSAMPLE = 16 (5200 clocks/bit), i_en = 1.
1. 8N1, i_ready = 1: frames 0x53, 0x2B, 0x01 back-to-back -> three o_valid handshakes with those values; error flags 0; o_overrun 0.
2. PARITY_MODE = 1: 0x53 sent with parity 0 -> o_parity_err = 0. Same frame with parity 1 -> o_data = 0x53, o_parity_err = 1.
3. Stop bit forced 0 on 0x2B -> o_frame_err = 1, data 0x2B. With NB_STOP = 2 and only the second stop bit 0 -> o_frame_err = 1.
4. i_ready = 0, frames 0x53 then 0x2B -> o_data stays 0x53, o_overrun = 1. Raise i_ready one cycle -> o_valid and o_overrun clear.
5. Glitches:
   - rx low for 2000 clocks, then high -> no o_valid, returns to IDLE.
   - a single 300-clock glitch inside a data bit of 0x53 -> still 0x53 (majority vote).
6. Aborts:
   - i_rst_n low mid-DATA -> all outputs 0 immediately; the next full frame 0x01 is received correctly.
   - i_en dropped mid-frame -> no o_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART blocks.
// Provides FSM state encoding, parity mode constants and majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversample tick generator, one o_tick every i_div clocks.
// Ports: i_restart clears the count and latches i_div (0 treated as 1).
module uart_tick_gen #(
  parameter int NB_DIV = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic [NB_DIV-1:0] i_div,
  output logic              o_tick
);

  logic [NB_DIV-1:0] cnt_q, cnt_d;
  logic [NB_DIV-1:0] div_q, div_d;
  logic              wrap;

  always_comb begin
    div_d = div_q;
    wrap  = (cnt_q == div_q - NB_DIV'(1));
    cnt_d = wrap ? '0 : cnt_q + NB_DIV'(1);
    if (i_restart) begin
      cnt_d = '0;
      div_d = (i_div == '0) ? NB_DIV'(1) : i_div;
    end
  end

  assign o_tick = wrap & ~i_restart;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      div_q <= NB_DIV'(1);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, majority-voted, valid/ready out.
// Ports: i_rx serial in, i_div tick divisor, o_data/o_valid/i_ready + flags.
module uart_rx_param #(
  parameter int NB_DATA     = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int NB_DIV      = 16,
  parameter int PARITY_MODE = 0,
  parameter int NB_STOP     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NB_DIV-1:0]  i_div,
  input  logic               i_rx,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_overrun,
  output logic               o_busy
);

  import uart_pkg::*;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB_DATA - 1);
  localparam logic          STOP_LAST = 1'(NB_STOP - 1);
  localparam logic          PAR_INV = (PARITY_MODE == PARITY_ODD);

  state_e state_q, state_d;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  logic [SW-1:0]      samp_q, samp_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               stop_q, stop_d;
  logic               s0_q, s0_d;
  logic               s1_q, s1_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;

  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               oferr_q, oferr_d;
  logic               operr_q, operr_d;
  logic               ovr_q, ovr_d;

  logic tick, restart, fall, vote;
  logic vote_tick, end_tick;
  logic done, done_ferr;

  uart_tick_gen #(
    .NB_DIV (NB_DIV)
  ) u_tick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (restart),
    .i_div     (i_div),
    .o_tick    (tick)
  );

  assign fall      = rx_prev_q & ~rx_s2_q;
  assign vote      = maj3(s0_q, s1_q, rx_s2_q);
  assign vote_tick = tick && (samp_q == S_V2);
  assign end_tick  = tick && (samp_q == S_END);

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    restart   = 1'b0;
    done      = 1'b0;
    done_ferr = ferr_q | ~vote;

    if (tick) begin
      samp_d = (samp_q == S_END) ? '0 : samp_q + SW'(1);
      if (samp_q == S_V0) s0_d = rx_s2_q;
      if (samp_q == S_V1) s1_d = rx_s2_q;
    end

    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d = ST_START;
            restart = 1'b1;
            samp_d  = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick && vote) begin
            state_d = ST_IDLE;
          end else if (end_tick) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (vote_tick) begin
            shift_d = {vote, shift_q[NB_DATA-1:1]};
          end
          if (end_tick) begin
            if (bit_q == B_LAST) begin
              state_d = (PARITY_MODE != PARITY_NONE)
                      ? ST_PARITY : ST_STOP;
              stop_d  = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (vote_tick) begin
            perr_d = vote ^ (^shift_q) ^ PAR_INV;
          end
          if (end_tick) begin
            state_d = ST_STOP;
            stop_d  = 1'b0;
          end
        end
        ST_STOP: begin
          if (vote_tick) begin
            if (!vote) ferr_d = 1'b1;
            // Completing at mid-stop lets the next start edge be caught.
            if (stop_q == STOP_LAST) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (end_tick) begin
            stop_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    oferr_d = oferr_q;
    operr_d = operr_q;
    ovr_d   = ovr_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        oferr_d = done_ferr;
        operr_d = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      samp_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      oferr_q   <= 1'b0;
      operr_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      oferr_q   <= oferr_d;
      operr_q   <= operr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = oferr_q;
  assign o_parity_err = operr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param (8N1, 8E1, 8N2 copies).
// Frames are driven bit by bit; delivered words are logged on handshake.
module tb_uart_rx_param;

  localparam int DIV = 8;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        ready = 1'b1;
  logic [15:0] div = 16'(DIV);
  logic        rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] a_data, b_data, c_data;
  logic a_valid, a_ferr, a_perr, a_ovr, a_busy;
  logic b_valid, b_ferr, b_perr, b_ovr, b_busy;
  logic c_valid, c_ferr, c_perr, c_ovr, c_busy;

  logic [9:0] qa[$], qb[$], qc[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.PARITY_MODE(0), .NB_STOP(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div),
    .i_rx(rx_a), .i_ready(ready), .o_data(a_data),
    .o_valid(a_valid), .o_frame_err(a_ferr),
    .o_parity_err(a_perr), .o_overrun(a_ovr), .o_busy(a_busy)
  );

  uart_rx_param #(.PARITY_MODE(1), .NB_STOP(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div),
    .i_rx(rx_b), .i_ready(ready), .o_data(b_data),
    .o_valid(b_valid), .o_frame_err(b_ferr),
    .o_parity_err(b_perr), .o_overrun(b_ovr), .o_busy(b_busy)
  );

  uart_rx_param #(.PARITY_MODE(0), .NB_STOP(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div),
    .i_rx(rx_c), .i_ready(ready), .o_data(c_data),
    .o_valid(c_valid), .o_frame_err(c_ferr),
    .o_parity_err(c_perr), .o_overrun(c_ovr), .o_busy(c_busy)
  );

  // Log {parity_err, frame_err, data} of every accepted word.
  always @(negedge clk) begin
    if (a_valid && ready) qa.push_back({a_perr, a_ferr, a_data});
    if (b_valid && ready) qb.push_back({b_perr, b_ferr, b_data});
    if (c_valid && ready) qc.push_back({c_perr, c_ferr, c_data});
  end

  task automatic set_rx(input int s, input logic v);
    case (s)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int s, input logic v);
    set_rx(s, v);
    idle(BIT);
  endtask

  // glitch_bit >= 0 inverts that data bit for 7 clocks around mid-bit,
  // hitting exactly one of the three vote samples.
  task automatic send_frame(
    input int         s,
    input logic [7:0] d,
    input bit         has_par,
    input logic       par,
    input logic       st1,
    input bit         two_stop,
    input logic       st2,
    input int         glitch_bit
  );
    send_bit(s, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        set_rx(s, d[i]);
        idle(71);
        set_rx(s, ~d[i]);
        idle(7);
        set_rx(s, d[i]);
        idle(BIT - 78);
      end else begin
        send_bit(s, d[i]);
      end
    end
    if (has_par) send_bit(s, par);
    send_bit(s, st1);
    if (two_stop) send_bit(s, st2);
    set_rx(s, 1'b1);
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++;
    if (a_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data got %h exp 00", a_data);
    end
    n_vec++;
    if ({a_valid, a_ferr, a_perr, a_ovr, a_busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 00000",
               {a_valid, a_ferr, a_perr, a_ovr, a_busy});
    end
    n_vec++;
    if ({b_valid, c_valid, b_busy, c_busy} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_bc got %b exp 0000",
               {b_valid, c_valid, b_busy, c_busy});
    end
    rst_n = 1'b1;
    idle(BIT);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    logic [9:0] got;
    int base;
    exp_d[0] = 8'h53;
    exp_d[1] = 8'h2B;
    exp_d[2] = 8'h01;
    base = qa.size();
    for (int i = 0; i < 3; i++)
      send_frame(0, exp_d[i], 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle(2 * BIT);
    n_vec++;
    if (qa.size() !== base + 3) begin
      n_err++;
      $display("FAIL b2b_count got %0d exp %0d", qa.size() - base, 3);
    end
    for (int i = 0; i < 3; i++) begin
      got = (qa.size() > base + i) ? qa[base + i] : 10'h3FF;
      n_vec++;
      if (got !== {2'b00, exp_d[i]}) begin
        n_err++;
        $display("FAIL b2b_word%0d got %h exp %h", i, got,
                 {2'b00, exp_d[i]});
      end
    end
    n_vec++;
    if (a_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_overrun got %b exp 0", a_ovr);
    end
  endtask

  task automatic test_parity();
    logic [9:0] got;
    int base;
    base = qb.size();
    // 0x53 has four ones: even parity bit 0 is correct, 1 is wrong.
    send_frame(1, 8'h53, 1, 1'b0, 1'b1, 0, 1'b1, -1);
    idle(BIT);
    send_frame(1, 8'h53, 1, 1'b1, 1'b1, 0, 1'b1, -1);
    idle(2 * BIT);
    got = (qb.size() > base) ? qb[base] : 10'h3FF;
    n_vec++;
    if (got !== 10'h053) begin
      n_err++;
      $display("FAIL parity_ok got %h exp 053", got);
    end
    got = (qb.size() > base + 1) ? qb[base + 1] : 10'h3FF;
    n_vec++;
    if (got !== 10'h253) begin
      n_err++;
      $display("FAIL parity_bad got %h exp 253", got);
    end
  endtask

  task automatic test_frame_err();
    logic [9:0] got;
    int base_a, base_c;
    base_a = qa.size();
    base_c = qc.size();
    send_frame(0, 8'h2B, 0, 1'b0, 1'b0, 0, 1'b1, -1);
    idle(2 * BIT);
    got = (qa.size() > base_a) ? qa[base_a] : 10'h3FF;
    n_vec++;
    if (got !== 10'h12B) begin
      n_err++;
      $display("FAIL ferr_stop1 got %h exp 12b", got);
    end
    send_frame(2, 8'h2B, 0, 1'b0, 1'b1, 1, 1'b0, -1);
    idle(2 * BIT);
    send_frame(2, 8'h2B, 0, 1'b0, 1'b1, 1, 1'b1, -1);
    idle(2 * BIT);
    got = (qc.size() > base_c) ? qc[base_c] : 10'h3FF;
    n_vec++;
    if (got !== 10'h12B) begin
      n_err++;
      $display("FAIL ferr_stop2 got %h exp 12b", got);
    end
    got = (qc.size() > base_c + 1) ? qc[base_c + 1] : 10'h3FF;
    n_vec++;
    if (got !== 10'h02B) begin
      n_err++;
      $display("FAIL ferr_2stop_ok got %h exp 02b", got);
    end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(0, 8'h53, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    n_vec++;
    if ({a_valid, a_ovr, a_data} !== {2'b10, 8'h53}) begin
      n_err++;
      $display("FAIL ovr_first got %b%b %h exp 10 53",
               a_valid, a_ovr, a_data);
    end
    send_frame(0, 8'h2B, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle(BIT);
    n_vec++;
    if ({a_valid, a_ovr, a_data} !== {2'b11, 8'h53}) begin
      n_err++;
      $display("FAIL ovr_hold got %b%b %h exp 11 53",
               a_valid, a_ovr, a_data);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_valid, a_ovr} !== 2'b00) begin
      n_err++;
      $display("FAIL ovr_clear got %b%b exp 00", a_valid, a_ovr);
    end
    ready = 1'b1;
    idle(BIT);
  endtask

  task automatic test_glitch();
    logic [9:0] got;
    int base;
    base = qa.size();
    set_rx(0, 1'b0);
    idle(49);
    set_rx(0, 1'b1);
    idle(2 * BIT);
    n_vec++;
    if ({qa.size() == base, a_busy, a_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL false_start got words=%0d busy=%b exp 0 0",
               qa.size() - base, a_busy);
    end
    send_frame(0, 8'h53, 0, 1'b0, 1'b1, 0, 1'b1, 0);
    idle(2 * BIT);
    got = (qa.size() > base) ? qa[base] : 10'h3FF;
    n_vec++;
    if (got !== 10'h053) begin
      n_err++;
      $display("FAIL glitch_vote got %h exp 053", got);
    end
  endtask

  task automatic test_abort_reset();
    logic [9:0] got;
    int base;
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    n_vec++;
    if (a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy_pre got %b exp 1", a_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_data, a_valid, a_ferr, a_perr, a_ovr, a_busy} !== 13'b0) begin
      n_err++;
      $display("FAIL rst_async got %h %b exp 00 00000", a_data,
               {a_valid, a_ferr, a_perr, a_ovr, a_busy});
    end
    set_rx(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BIT);
    base = qa.size();
    send_frame(0, 8'h01, 0, 1'b0, 1'b1, 0, 1'b1, -1);
    idle(2 * BIT);
    got = (qa.size() > base) ? qa[base] : 10'h3FF;
    n_vec++;
    if (got !== 10'h001) begin
      n_err++;
      $display("FAIL rst_next got %h exp 001", got);
    end
  endtask

  task automatic test_abort_en();
    logic [7:0] d;
    int base;
    d = 8'h53;
    base = qa.size();
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, d[i]);
    n_vec++;
    if (a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL en_busy_pre got %b exp 1", a_busy);
    end
    en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_idle got %b exp 0", a_busy);
    end
    for (int i = 3; i < 8; i++) send_bit(0, d[i]);
    send_bit(0, 1'b1);
    idle(BIT);
    en = 1'b1;
    idle(2 * BIT);
    n_vec++;
    if ({qa.size() == base, a_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL en_drop got words=%0d valid=%b exp 0 0",
               qa.size() - base, a_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_abort_reset();
    test_abort_en();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
